// File: rtl/fetch_unit_if.sv
// Instruction bus between the fetch unit (master) and the instruction memory (slave).
// A request stays asserted with a stable address until the cycle iresp_data_ok=1.
interface fetch_unit_if;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;

   modport master (
      output ireq_valid,
      output ireq_addr,
      input  iresp_data_ok,
      input  iresp_data
   );

   modport slave (
      input  ireq_valid,
      input  ireq_addr,
      output iresp_data_ok,
      output iresp_data
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: REQ/HOLD/DISCARD FSM with a one-entry hold buffer and redirect.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned pc emits one NOP with out_exc=1 and no bus request.
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master ibus,
   input  logic         stall,
   input  logic         redirect_valid,
   input  logic [63:0]  redirect_pc,
   output logic         out_valid,
   output logic [63:0]  out_pc,
   output logic [31:0]  out_raw_instr,
   output logic         out_exc
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ     = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [63:0] pc_reg, pc_next;
   logic [63:0] discard_addr_reg, discard_addr_next;
   logic [63:0] hold_pc_reg, hold_pc_next;
   logic [31:0] hold_instr_reg, hold_instr_next;
   logic        out_valid_reg, out_valid_next;
   logic [63:0] out_pc_reg, out_pc_next;
   logic [31:0] out_instr_reg, out_instr_next;
   logic        out_exc_reg, out_exc_next;
   logic        exc_done_reg, exc_done_next;

   logic        req_valid;
   logic [63:0] req_addr;
   logic        slot_free;
   logic        consumed;
   logic        misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign misaligned = (pc_reg[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   assign slot_free = !out_valid_reg || !stall;
   assign consumed  = out_valid_reg && !stall;

   // Bus outputs depend only on registered state, so the address cannot wobble mid-request.
   always_comb begin
      req_valid = 1'b0;
      req_addr  = pc_reg;
      case (state_reg)
         REQ:     req_valid = !misaligned;
         DISCARD: begin
            req_valid = 1'b1;
            req_addr  = discard_addr_reg;
         end
         default: req_valid = 1'b0;
      endcase
   end

   assign ibus.ireq_valid = req_valid;
   assign ibus.ireq_addr  = req_addr;

   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      discard_addr_next = discard_addr_reg;
      hold_pc_next      = hold_pc_reg;
      hold_instr_next   = hold_instr_reg;
      out_valid_next    = out_valid_reg;
      out_pc_next       = out_pc_reg;
      out_instr_next    = out_instr_reg;
      out_exc_next      = out_exc_reg;
      exc_done_next     = exc_done_reg;

      if (redirect_valid) begin
         pc_next        = redirect_pc;
         out_valid_next = 1'b0;
         exc_done_next  = 1'b0;
         case (state_reg)
            REQ: begin
               // An unanswered request must still be completed on the bus, then dropped.
               if (req_valid && !ibus.iresp_data_ok) begin
                  state_next        = DISCARD;
                  discard_addr_next = pc_reg;
               end else begin
                  state_next = REQ;
               end
            end
            HOLD:    state_next = REQ;
            DISCARD: state_next = ibus.iresp_data_ok ? REQ : DISCARD;
            default: state_next = REQ;
         endcase
      end else begin
         case (state_reg)
            REQ: begin
               if (misaligned) begin
                  if (!exc_done_reg && slot_free) begin
                     out_valid_next = 1'b1;
                     out_pc_next    = pc_reg;
                     out_instr_next = NOP_INSTR;
                     out_exc_next   = 1'b1;
                     exc_done_next  = 1'b1;
                  end else if (consumed) begin
                     out_valid_next = 1'b0;
                  end
               end else if (ibus.iresp_data_ok) begin
                  pc_next = pc_reg + 64'd4;
                  if (slot_free) begin
                     out_valid_next = 1'b1;
                     out_pc_next    = pc_reg;
                     out_instr_next = ibus.iresp_data;
                     out_exc_next   = 1'b0;
                  end else begin
                     hold_pc_next    = pc_reg;
                     hold_instr_next = ibus.iresp_data;
                     state_next      = HOLD;
                  end
               end else if (consumed) begin
                  out_valid_next = 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  out_valid_next = 1'b1;
                  out_pc_next    = hold_pc_reg;
                  out_instr_next = hold_instr_reg;
                  out_exc_next   = 1'b0;
                  state_next     = REQ;
               end
            end
            DISCARD: begin
               if (ibus.iresp_data_ok) begin
                  state_next = REQ;
               end
            end
            default: state_next = REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= REQ;
         pc_reg           <= RESET_PC;
         discard_addr_reg <= 64'd0;
         hold_pc_reg      <= 64'd0;
         hold_instr_reg   <= 32'd0;
         out_valid_reg    <= 1'b0;
         out_pc_reg       <= 64'd0;
         out_instr_reg    <= 32'd0;
         out_exc_reg      <= 1'b0;
         exc_done_reg     <= 1'b0;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         discard_addr_reg <= discard_addr_next;
         hold_pc_reg      <= hold_pc_next;
         hold_instr_reg   <= hold_instr_next;
         out_valid_reg    <= out_valid_next;
         out_pc_reg       <= out_pc_next;
         out_instr_reg    <= out_instr_next;
         out_exc_reg      <= out_exc_next;
         exc_done_reg     <= exc_done_next;
      end
   end

   assign out_valid     = out_valid_reg;
   assign out_pc        = out_pc_reg;
   assign out_raw_instr = out_instr_reg;
   assign out_exc       = out_exc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; the misalign scenario follows FETCH_MISALIGN_CHECK_EN.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic [63:0] out_pc;
   logic [31:0] out_raw_instr;
   logic        out_exc;

   int checks = 0;
   int errors = 0;

   fetch_unit_if ibus ();

   fetch_unit #(.RESET_PC(64'h8000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .ibus           (ibus),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_raw_instr  (out_raw_instr),
      .out_exc        (out_exc)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 64'h1234;
      ibus.iresp_data_ok = 1'b1; ibus.iresp_data = 32'hFFFF_FFFF;
      tick(); tick();
      checks++;
      if ({out_valid, out_pc, out_raw_instr, out_exc} !== 98'd0) begin
         errors++;
         $display("FAIL reset_out: got v=%0b pc=%h instr=%h exc=%0b expected all zero", out_valid, out_pc, out_raw_instr, out_exc);
      end
      checks++;
      if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_0000}) begin
         errors++;
         $display("FAIL reset_req: got v=%0b addr=%h expected v=1 addr=80000000", ibus.ireq_valid, ibus.ireq_addr);
      end
      reset = 1'b0; redirect_valid = 1'b0; ibus.iresp_data_ok = 1'b0;
      tick();
      checks++;
      if ({ibus.ireq_valid, ibus.ireq_addr, out_valid} !== {1'b1, 64'h8000_0000, 1'b0}) begin
         errors++;
         $display("FAIL reset_release: got v=%0b addr=%h ov=%0b expected v=1 addr=80000000 ov=0", ibus.ireq_valid, ibus.ireq_addr, out_valid);
      end
      $display("reset: release checked");
   endtask

   task automatic test_zero_wait();
      ibus.iresp_data_ok = 1'b1; ibus.iresp_data = 32'h0000_0093;
      tick();
      ibus.iresp_data = 32'h0000_0113;
      checks++;
      if ({out_valid, out_pc, out_raw_instr, ibus.ireq_addr} !== {1'b1, 64'h8000_0000, 32'h0000_0093, 64'h8000_0004}) begin
         errors++;
         $display("FAIL zw_first: got v=%0b pc=%h instr=%h next=%h expected 1 80000000 00000093 80000004", out_valid, out_pc, out_raw_instr, ibus.ireq_addr);
      end
      tick();
      ibus.iresp_data_ok = 1'b0;
      checks++;
      if ({out_valid, out_pc, out_raw_instr, ibus.ireq_addr} !== {1'b1, 64'h8000_0004, 32'h0000_0113, 64'h8000_0008}) begin
         errors++;
         $display("FAIL zw_second: got v=%0b pc=%h instr=%h next=%h expected 1 80000004 00000113 80000008", out_valid, out_pc, out_raw_instr, ibus.ireq_addr);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL zw_drain: got out_valid=%0b expected 0", out_valid);
      end
      $display("zero_wait: two back-to-back fetches checked");
   endtask

   task automatic test_hold();
      ibus.iresp_data_ok = 1'b1; ibus.iresp_data = 32'h0000_00A1;
      tick();
      stall = 1'b1; ibus.iresp_data = 32'h0000_00A2;
      tick();
      ibus.iresp_data_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({ibus.ireq_valid, out_valid, out_pc, out_raw_instr} !== {1'b0, 1'b1, 64'h8000_0008, 32'h0000_00A1}) begin
            errors++;
            $display("FAIL hold_stall%0d: got req=%0b v=%0b pc=%h instr=%h expected 0 1 80000008 000000a1", i, ibus.ireq_valid, out_valid, out_pc, out_raw_instr);
         end
         if (i < 2) tick();
      end
      stall = 1'b0;
      tick();
      checks++;
      if ({out_valid, out_pc, out_raw_instr, ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_000C, 32'h0000_00A2, 1'b1, 64'h8000_0010}) begin
         errors++;
         $display("FAIL hold_release: got v=%0b pc=%h instr=%h req=%0b addr=%h expected 1 8000000c 000000a2 1 80000010", out_valid, out_pc, out_raw_instr, ibus.ireq_valid, ibus.ireq_addr);
      end
      $display("hold: buffered word released after stall");
   endtask

   task automatic test_redirect_pending();
      reset = 1'b1;
      tick();
      reset = 1'b0; ibus.iresp_data_ok = 1'b1; ibus.iresp_data = 32'h10;
      tick();
      ibus.iresp_data = 32'h14;
      tick();
      ibus.iresp_data_ok = 1'b0;
      tick();
      checks++;
      if ({ibus.ireq_valid, ibus.ireq_addr, out_valid} !== {1'b1, 64'h8000_0008, 1'b0}) begin
         errors++;
         $display("FAIL pend_wait1: got req=%0b addr=%h ov=%0b expected 1 80000008 0", ibus.ireq_valid, ibus.ireq_addr, out_valid);
      end
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({ibus.ireq_valid, ibus.ireq_addr, out_valid} !== {1'b1, 64'h8000_0008, 1'b0}) begin
            errors++;
            $display("FAIL pend_discard%0d: got req=%0b addr=%h ov=%0b expected 1 80000008 0", i, ibus.ireq_valid, ibus.ireq_addr, out_valid);
         end
         if (i == 0) tick();
      end
      ibus.iresp_data_ok = 1'b1; ibus.iresp_data = 32'hDEAD_BEEF;
      tick();
      ibus.iresp_data_ok = 1'b0;
      checks++;
      if ({ibus.ireq_valid, ibus.ireq_addr, out_valid} !== {1'b1, 64'h8000_0100, 1'b0}) begin
         errors++;
         $display("FAIL pend_dropped: got req=%0b addr=%h ov=%0b expected 1 80000100 0", ibus.ireq_valid, ibus.ireq_addr, out_valid);
      end
      ibus.iresp_data_ok = 1'b1; ibus.iresp_data = 32'h55;
      tick();
      ibus.iresp_data_ok = 1'b0;
      checks++;
      if ({out_valid, out_pc, out_raw_instr} !== {1'b1, 64'h8000_0100, 32'h55}) begin
         errors++;
         $display("FAIL pend_target: got v=%0b pc=%h instr=%h expected 1 80000100 00000055", out_valid, out_pc, out_raw_instr);
      end
      $display("redirect_pending: in-flight response dropped");
   endtask

   task automatic test_redirect_same_cycle();
      stall = 1'b1; ibus.iresp_data_ok = 1'b1; ibus.iresp_data = 32'h0BAD;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
      tick();
      redirect_valid = 1'b0; ibus.iresp_data_ok = 1'b0; stall = 1'b0;
      checks++;
      if ({out_valid, ibus.ireq_valid, ibus.ireq_addr} !== {1'b0, 1'b1, 64'h8000_0200}) begin
         errors++;
         $display("FAIL same_cycle: got ov=%0b req=%0b addr=%h expected 0 1 80000200", out_valid, ibus.ireq_valid, ibus.ireq_addr);
      end
      $display("redirect_same_cycle: data dropped under stall");
   endtask

   task automatic test_redirect_hold();
      ibus.iresp_data_ok = 1'b1; ibus.iresp_data = 32'h31;
      tick();
      stall = 1'b1; ibus.iresp_data = 32'h32;
      tick();
      ibus.iresp_data_ok = 1'b0;
      checks++;
      if (ibus.ireq_valid !== 1'b0) begin
         errors++;
         $display("FAIL rh_hold: got req=%0b expected 0", ibus.ireq_valid);
      end
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
      tick();
      redirect_valid = 1'b0; stall = 1'b0;
      checks++;
      if ({out_valid, ibus.ireq_valid, ibus.ireq_addr} !== {1'b0, 1'b1, 64'h8000_0400}) begin
         errors++;
         $display("FAIL rh_redirect: got ov=%0b req=%0b addr=%h expected 0 1 80000400", out_valid, ibus.ireq_valid, ibus.ireq_addr);
      end
      $display("redirect_hold: hold buffer discarded");
   endtask

   task automatic test_wrap();
      ibus.iresp_data_ok = 1'b1; ibus.iresp_data = 32'h0;
      redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      redirect_valid = 1'b0; ibus.iresp_data = 32'h1;
      tick();
      ibus.iresp_data_ok = 1'b0;
      checks++;
      if ({out_valid, out_pc, ibus.ireq_addr} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0}) begin
         errors++;
         $display("FAIL wrap: got v=%0b pc=%h next=%h expected 1 fffffffffffffffc 0", out_valid, out_pc, ibus.ireq_addr);
      end
      $display("wrap: pc wrapped to zero");
   endtask

   task automatic test_misalign();
      ibus.iresp_data_ok = 1'b1; ibus.iresp_data = 32'h0;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
      tick();
      redirect_valid = 1'b0; ibus.iresp_data_ok = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      checks++;
      if (ibus.ireq_valid !== 1'b0) begin
         errors++;
         $display("FAIL mis_noreq: got req=%0b expected 0", ibus.ireq_valid);
      end
      tick();
      checks++;
      if ({out_valid, out_pc, out_raw_instr, out_exc, ibus.ireq_valid} !== {1'b1, 64'h8000_0102, 32'h0000_0013, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL mis_exc: got v=%0b pc=%h instr=%h exc=%0b req=%0b expected 1 80000102 00000013 1 0", out_valid, out_pc, out_raw_instr, out_exc, ibus.ireq_valid);
      end
      tick();
      checks++;
      if ({out_valid, ibus.ireq_valid} !== 2'b00) begin
         errors++;
         $display("FAIL mis_once: got v=%0b req=%0b expected 0 0", out_valid, ibus.ireq_valid);
      end
`else
      checks++;
      if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_0102}) begin
         errors++;
         $display("FAIL mis_req: got req=%0b addr=%h expected 1 80000102", ibus.ireq_valid, ibus.ireq_addr);
      end
      ibus.iresp_data_ok = 1'b1; ibus.iresp_data = 32'h99;
      tick();
      ibus.iresp_data_ok = 1'b0;
      checks++;
      if ({out_valid, out_pc, out_exc, ibus.ireq_addr} !== {1'b1, 64'h8000_0102, 1'b0, 64'h8000_0106}) begin
         errors++;
         $display("FAIL mis_plain: got v=%0b pc=%h exc=%0b next=%h expected 1 80000102 0 80000106", out_valid, out_pc, out_exc, ibus.ireq_addr);
      end
`endif
      $display("misalign: redirect to 80000102 checked");
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
      ibus.iresp_data_ok = 1'b0; ibus.iresp_data = 32'd0;
      test_reset();
      test_zero_wait();
      test_hold();
      test_redirect_pending();
      test_redirect_same_cycle();
      test_redirect_hold();
      test_wrap();
      test_misalign();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
